// File: rtl/vga_overlay_pkg.sv
// Shared definitions for the VGA dot/goal overlay: write-field codes,
// attribute bit positions, colour type, default colours, commit FSM states.
package vga_overlay_pkg;

    typedef logic [11:0] color_t;

    localparam logic [1:0] FLD_X    = 2'd0;
    localparam logic [1:0] FLD_Y    = 2'd1;
    localparam logic [1:0] FLD_ATTR = 2'd2;
    localparam logic [1:0] FLD_GOAL = 2'd3;

    localparam int ATTR_EN    = 0;
    localparam int ATTR_CHAMP = 1;

    localparam color_t DEF_DOT_COLOR   = 12'h000;
    localparam color_t DEF_CHAMP_COLOR = 12'hF00;
    localparam color_t DEF_GOAL_COLOR  = 12'h0D0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PENDING,
        ST_COPY
    } commit_state_t;

endpackage

// File: rtl/dot_overlay_engine_cell.sv
// One dot slot: shadow/active position+attribute registers and the
// stage-1 square hit compare against the current raster coordinate.
// Ports: clk/reset; wr_x/wr_y/wr_attr shadow write strobes with data;
// copy (shadow->active); x/y raster; hit and champ_hit (combinational).
import vga_overlay_pkg::*;

module dot_hit_cell #(
    parameter int X_W        = 10,
    parameter int Y_W        = 9,
    parameter int DOT_SIZE   = 1,
    parameter int DOT_X_INIT = 320,
    parameter int DOT_Y_INIT = 240
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           wr_x,
    input  logic           wr_y,
    input  logic           wr_attr,
    input  logic [X_W-1:0] wr_x_data,
    input  logic [Y_W-1:0] wr_y_data,
    input  logic [1:0]     wr_attr_data,
    input  logic           copy,
    input  logic [X_W-1:0] x,
    input  logic [Y_W-1:0] y,
    output logic           hit,
    output logic           champ_hit
);

    localparam logic [X_W-1:0] X_INIT = X_W'(DOT_X_INIT);
    localparam logic [Y_W-1:0] Y_INIT = Y_W'(DOT_Y_INIT);
    localparam logic [X_W:0]   SZ_X   = (X_W+1)'(DOT_SIZE);
    localparam logic [Y_W:0]   SZ_Y   = (Y_W+1)'(DOT_SIZE);

    logic [X_W-1:0] sh_x, act_x;
    logic [Y_W-1:0] sh_y, act_y;
    logic           sh_en, sh_ch, act_en, act_ch;

    always_ff @(posedge clk) begin
        if (reset) begin
            sh_x   <= X_INIT;
            sh_y   <= Y_INIT;
            sh_en  <= 1'b1;
            sh_ch  <= 1'b0;
            act_x  <= X_INIT;
            act_y  <= Y_INIT;
            act_en <= 1'b1;
            act_ch <= 1'b0;
        end else begin
            if (wr_x)
                sh_x <= wr_x_data;
            if (wr_y)
                sh_y <= wr_y_data;
            if (wr_attr) begin
                sh_en <= wr_attr_data[ATTR_EN];
                sh_ch <= wr_attr_data[ATTR_CHAMP];
            end
            if (copy) begin
                act_x  <= sh_x;
                act_y  <= sh_y;
                act_en <= sh_en;
                act_ch <= sh_ch;
            end
        end
    end

    // One extra bit so a dot at the right/bottom edge cannot wrap to 0.
    logic [X_W:0] xe, lo_x;
    logic [Y_W:0] ye, lo_y;

    assign xe   = {1'b0, x};
    assign ye   = {1'b0, y};
    assign lo_x = {1'b0, act_x};
    assign lo_y = {1'b0, act_y};

    assign hit = act_en
              && (xe >= lo_x) && (xe < lo_x + SZ_X)
              && (ye >= lo_y) && (ye < lo_y + SZ_Y);

    assign champ_hit = hit && act_ch;

endmodule

// File: rtl/dot_overlay_engine.sv
// Per-pixel overlay of NUM_DOTS dots and a goal box over the background.
// Ports: clk/reset; pix_en,x,y,active,screen_end,bg_color raster side;
// wr_en/wr_field/wr_id/wr_data/wr_ready shadow writes; commit_req,
// frame_done commit; wr_err sticky bad-id flag; color_out (2 strobes late).
import vga_overlay_pkg::*;

module dot_overlay_engine #(
    parameter int     NUM_DOTS    = 45,
    parameter int     X_W         = 10,
    parameter int     Y_W         = 9,
    parameter int     DOT_SIZE    = 1,
    parameter int     GOAL_SIZE   = 20,
    parameter int     GOAL_X_INIT = 310,
    parameter int     GOAL_Y_INIT = 50,
    parameter int     DOT_X_INIT  = 320,
    parameter int     DOT_Y_INIT  = 240,
    parameter color_t DOT_COLOR   = DEF_DOT_COLOR,
    parameter color_t CHAMP_COLOR = DEF_CHAMP_COLOR,
    parameter color_t GOAL_COLOR  = DEF_GOAL_COLOR
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           pix_en,
    input  logic [X_W-1:0] x,
    input  logic [Y_W-1:0] y,
    input  logic           active,
    input  logic           screen_end,
    input  color_t         bg_color,
    input  logic           wr_en,
    input  logic [1:0]     wr_field,
    input  logic [31:0]    wr_id,
    input  logic [31:0]    wr_data,
    output logic           wr_ready,
    input  logic           commit_req,
    output logic           frame_done,
    output logic           wr_err,
    output color_t         color_out
);

    localparam logic [X_W-1:0] GX_INIT = X_W'(GOAL_X_INIT);
    localparam logic [Y_W-1:0] GY_INIT = Y_W'(GOAL_Y_INIT);
    localparam logic [X_W:0]   GSZ_X   = (X_W+1)'(GOAL_SIZE);
    localparam logic [Y_W:0]   GSZ_Y   = (Y_W+1)'(GOAL_SIZE);

    // ---------------- commit control ----------------
    // state only rests in IDLE/PENDING; phase is what this cycle does,
    // and COPY lasts exactly the one clk of the shadow->active transfer.
    commit_state_t state, state_nx, phase;
    logic          frame_end, copy;

    assign frame_end = !reset && pix_en && screen_end;

    always_comb begin
        state_nx = state;
        phase    = state;
        unique case (state)
            ST_IDLE: begin
                if (frame_end && commit_req)
                    phase = ST_COPY;
                else if (commit_req)
                    state_nx = ST_PENDING;
            end
            ST_PENDING: begin
                if (frame_end)
                    phase = ST_COPY;
            end
            default: begin
                phase    = ST_IDLE;
                state_nx = ST_IDLE;
            end
        endcase
        if (phase == ST_COPY)
            state_nx = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    assign copy       = (phase == ST_COPY);
    assign frame_done = copy;
    assign wr_ready   = !copy;

    // ---------------- shadow writes ----------------
    logic wr_fire, id_ok;

    assign wr_fire = wr_en && wr_ready && !reset;
    assign id_ok   = wr_id < 32'(NUM_DOTS);

    always_ff @(posedge clk) begin
        if (reset)
            wr_err <= 1'b0;
        else if (wr_fire && !id_ok && wr_field != FLD_GOAL)
            wr_err <= 1'b1;
    end

    logic unused_wr_data;
    assign unused_wr_data = ^wr_data[31:X_W+Y_W];

    // ---------------- dot slots ----------------
    logic [NUM_DOTS-1:0] hit_vec, champ_vec;

    for (genvar i = 0; i < NUM_DOTS; i++) begin : g_dot
        logic sel;
        assign sel = wr_fire && id_ok && (wr_id == 32'(i));

        dot_hit_cell #(
            .X_W        (X_W),
            .Y_W        (Y_W),
            .DOT_SIZE   (DOT_SIZE),
            .DOT_X_INIT (DOT_X_INIT),
            .DOT_Y_INIT (DOT_Y_INIT)
        ) u_cell (
            .clk          (clk),
            .reset        (reset),
            .wr_x         (sel && wr_field == FLD_X),
            .wr_y         (sel && wr_field == FLD_Y),
            .wr_attr      (sel && wr_field == FLD_ATTR),
            .wr_x_data    (wr_data[X_W-1:0]),
            .wr_y_data    (wr_data[Y_W-1:0]),
            .wr_attr_data (wr_data[1:0]),
            .copy         (copy),
            .x            (x),
            .y            (y),
            .hit          (hit_vec[i]),
            .champ_hit    (champ_vec[i])
        );
    end

    // ---------------- goal box ----------------
    logic [X_W-1:0] sh_gx, act_gx;
    logic [Y_W-1:0] sh_gy, act_gy;

    always_ff @(posedge clk) begin
        if (reset) begin
            sh_gx  <= GX_INIT;
            sh_gy  <= GY_INIT;
            act_gx <= GX_INIT;
            act_gy <= GY_INIT;
        end else begin
            if (wr_fire && wr_field == FLD_GOAL) begin
                sh_gx <= wr_data[X_W-1:0];
                sh_gy <= wr_data[X_W+Y_W-1:X_W];
            end
            if (copy) begin
                act_gx <= sh_gx;
                act_gy <= sh_gy;
            end
        end
    end

    logic [X_W:0] xe, gxe;
    logic [Y_W:0] ye, gye;
    logic         goal_hit;

    assign xe  = {1'b0, x};
    assign ye  = {1'b0, y};
    assign gxe = {1'b0, act_gx};
    assign gye = {1'b0, act_gy};

    assign goal_hit = (xe >= gxe) && (xe < gxe + GSZ_X)
                   && (ye >= gye) && (ye < gye + GSZ_Y);

    // ---------------- pixel pipeline ----------------
    logic   s1_active, s1_hit, s1_champ, s1_goal;
    color_t s1_bg;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_active <= 1'b0;
            s1_hit    <= 1'b0;
            s1_champ  <= 1'b0;
            s1_goal   <= 1'b0;
            s1_bg     <= '0;
            color_out <= '0;
        end else if (pix_en) begin
            s1_active <= active;
            s1_hit    <= |hit_vec;
            s1_champ  <= |champ_vec;
            s1_goal   <= goal_hit;
            s1_bg     <= bg_color;
            if (!s1_active)
                color_out <= '0;
            else if (s1_champ)
                color_out <= CHAMP_COLOR;
            else if (s1_hit)
                color_out <= DOT_COLOR;
            else if (s1_goal)
                color_out <= GOAL_COLOR;
            else
                color_out <= s1_bg;
        end
    end

endmodule

// File: tb/tb_dot_overlay_engine.sv
// Self-checking bench for dot_overlay_engine: directed scenarios plus
// randomized writes/pixels against a behavioural array model.
module tb_dot_overlay_engine;

    localparam int N = 45;

    logic        clk = 1'b0;
    logic        reset, pix_en, active, screen_end, wr_en, commit_req;
    logic [9:0]  x;
    logic [8:0]  y;
    logic [11:0] bg_color;
    logic [1:0]  wr_field;
    logic [31:0] wr_id, wr_data;
    logic        wr_ready, frame_done, wr_err;
    logic [11:0] color_out;
    logic        wr_ready4, frame_done4, wr_err4;
    logic [11:0] color_out4;

    always #5 clk = ~clk;

    dot_overlay_engine u_dut (
        .clk(clk), .reset(reset), .pix_en(pix_en), .x(x), .y(y),
        .active(active), .screen_end(screen_end), .bg_color(bg_color),
        .wr_en(wr_en), .wr_field(wr_field), .wr_id(wr_id),
        .wr_data(wr_data), .wr_ready(wr_ready), .commit_req(commit_req),
        .frame_done(frame_done), .wr_err(wr_err), .color_out(color_out)
    );

    dot_overlay_engine #(.DOT_SIZE(4)) u_dut4 (
        .clk(clk), .reset(reset), .pix_en(pix_en), .x(x), .y(y),
        .active(active), .screen_end(screen_end), .bg_color(bg_color),
        .wr_en(wr_en), .wr_field(wr_field), .wr_id(wr_id),
        .wr_data(wr_data), .wr_ready(wr_ready4), .commit_req(commit_req),
        .frame_done(frame_done4), .wr_err(wr_err4), .color_out(color_out4)
    );

    int checks = 0;
    int errors = 0;

    // model: shadow (s*) and active (a*) copies
    int  sx[N], sy[N], ax[N], ay[N];
    bit  sen[N], sch[N], aen[N], ach[N];
    int  sgx, sgy, agx, agy;
    bit  m_pend, m_err;
    logic [11:0] prev1, prev4;

    function automatic void mdl_reset();
        for (int i = 0; i < N; i++) begin
            sx[i] = 320; sy[i] = 240; sen[i] = 1; sch[i] = 0;
            ax[i] = 320; ay[i] = 240; aen[i] = 1; ach[i] = 0;
        end
        sgx = 310; sgy = 50; agx = 310; agy = 50;
        m_pend = 0; m_err = 0;
    endfunction

    function automatic void mdl_write(input logic [1:0] f, input int id,
                                      input logic [31:0] d);
        if (f == 2'd3) begin
            sgx = int'(d & 32'd1023);
            sgy = int'((d >> 10) & 32'd511);
        end else if (id >= N || id < 0) begin
            m_err = 1;
        end else if (f == 2'd0) begin
            sx[id] = int'(d & 32'd1023);
        end else if (f == 2'd1) begin
            sy[id] = int'(d & 32'd511);
        end else begin
            sen[id] = d[0];
            sch[id] = d[1];
        end
    endfunction

    function automatic void mdl_copy();
        for (int i = 0; i < N; i++) begin
            ax[i] = sx[i]; ay[i] = sy[i]; aen[i] = sen[i]; ach[i] = sch[i];
        end
        agx = sgx; agy = sgy;
    endfunction

    function automatic logic [11:0] ref_color(input int px, input int py,
                                              input bit act,
                                              input logic [11:0] bg,
                                              input int size);
        bit any, ch, g;
        any = 0; ch = 0;
        if (!act) return 12'h000;
        for (int i = 0; i < N; i++)
            if (aen[i] && px >= ax[i] && px < ax[i] + size &&
                py >= ay[i] && py < ay[i] + size) begin
                any = 1;
                if (ach[i]) ch = 1;
            end
        g = px >= agx && px < agx + 20 && py >= agy && py < agy + 20;
        if (ch)  return 12'hF00;
        if (any) return 12'h000;
        if (g)   return 12'h0D0;
        return bg;
    endfunction

    task automatic pix(input int px, input int py, input bit act,
                       input bit se, input logic [11:0] bg,
                       input bit creq = 0, input bit we = 0,
                       input logic [1:0] wf = 2'd0, input int wid = 0,
                       input logic [31:0] wd = 32'd0);
        bit cp;
        logic [11:0] e1, e4;
        int qx, qy;
        qx = px & 1023;
        qy = py & 511;
        @(negedge clk);
        x = qx[9:0]; y = qy[8:0]; active = act; screen_end = se;
        bg_color = bg; commit_req = creq; pix_en = 1;
        wr_en = we; wr_field = wf; wr_id = wid; wr_data = wd;
        cp = se && (m_pend || creq);
        #1;
        checks++;
        if (frame_done !== cp || frame_done4 !== cp) begin
            errors++;
            $display("FAIL frame_done got %b/%b want %b",
                     frame_done, frame_done4, cp);
        end
        checks++;
        if (wr_ready !== !cp || wr_ready4 !== !cp) begin
            errors++;
            $display("FAIL wr_ready got %b/%b want %b",
                     wr_ready, wr_ready4, !cp);
        end
        @(posedge clk);
        e1 = ref_color(qx, qy, act, bg, 1);
        e4 = ref_color(qx, qy, act, bg, 4);
        if (we && !cp) mdl_write(wf, wid, wd);
        if (cp) begin
            mdl_copy();
            m_pend = 0;
        end else if (creq) begin
            m_pend = 1;
        end
        #1;
        checks++;
        if (color_out !== prev1) begin
            errors++;
            $display("FAIL color_out got %h want %h", color_out, prev1);
        end
        checks++;
        if (color_out4 !== prev4) begin
            errors++;
            $display("FAIL color_out4 got %h want %h", color_out4, prev4);
        end
        prev1 = e1;
        prev4 = e4;
        @(negedge clk);
        pix_en = 0; screen_end = 0; commit_req = 0; wr_en = 0;
        repeat (2) @(negedge clk);
    endtask

    task automatic wr(input logic [1:0] f, input int id,
                      input logic [31:0] d);
        @(negedge clk);
        wr_en = 1; wr_field = f; wr_id = id; wr_data = d;
        #1;
        checks++;
        if (wr_ready !== 1'b1 || wr_ready4 !== 1'b1) begin
            errors++;
            $display("FAIL wr_ready_idle got %b/%b want 1",
                     wr_ready, wr_ready4);
        end
        @(posedge clk);
        mdl_write(f, id, d);
        @(negedge clk);
        wr_en = 0;
        #1;
        checks++;
        if (wr_err !== m_err || wr_err4 !== m_err) begin
            errors++;
            $display("FAIL wr_err got %b/%b want %b", wr_err, wr_err4, m_err);
        end
    endtask

    task automatic end_frame(input bit creq);
        pix(0, 500, 0, 1, 12'h000, creq);
    endtask

    task automatic probe(input string nm, input int px, input int py,
                         input bit act, input logic [11:0] want1,
                         input logic [11:0] want4);
        pix(px, py, act, 0, 12'h123);
        pix(0, 500, 0, 0, 12'h000);
        checks++;
        if (color_out !== want1) begin
            errors++;
            $display("FAIL %s size1 got %h want %h", nm, color_out, want1);
        end
        checks++;
        if (color_out4 !== want4) begin
            errors++;
            $display("FAIL %s size4 got %h want %h", nm, color_out4, want4);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1; pix_en = 0; active = 0; screen_end = 0; commit_req = 0;
        wr_en = 0; wr_field = 0; wr_id = 0; wr_data = 0;
        x = 0; y = 0; bg_color = 0;
        repeat (3) @(negedge clk);
        reset = 0;
        mdl_reset();
        prev1 = 0;
        prev4 = 0;
        #1;
        checks++;
        if (color_out !== 12'h000 || frame_done !== 1'b0 ||
            wr_ready !== 1'b1 || wr_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got c=%h fd=%b rdy=%b err=%b want 000 0 1 0",
                     color_out, frame_done, wr_ready, wr_err);
        end
    endtask

    task automatic test_defaults();
        probe("dflt_dot", 320, 240, 1, 12'h000, 12'h000);
        probe("dflt_dot_right", 321, 240, 1, 12'h123, 12'h000);
        probe("dflt_bg", 200, 100, 1, 12'h123, 12'h123);
        probe("goal_tl", 310, 50, 1, 12'h0D0, 12'h0D0);
        probe("goal_br", 329, 69, 1, 12'h0D0, 12'h0D0);
        probe("goal_out_r", 330, 69, 1, 12'h123, 12'h123);
        probe("goal_out_l", 309, 50, 1, 12'h123, 12'h123);
    endtask

    task automatic test_commit();
        wr(2'd0, 3, 32'd100);
        wr(2'd1, 3, 32'd200);
        end_frame(0);
        probe("nocommit_old", 320, 240, 1, 12'h000, 12'h000);
        probe("nocommit_new", 100, 200, 1, 12'h123, 12'h123);
        end_frame(1);
        end_frame(0);
        probe("commit_new", 100, 200, 1, 12'h000, 12'h000);
    endtask

    task automatic test_champion();
        wr(2'd2, 3, 32'd3);
        end_frame(1);
        probe("champ", 100, 200, 1, 12'hF00, 12'hF00);
        wr(2'd0, 4, 32'd100);
        wr(2'd1, 4, 32'd200);
        end_frame(1);
        probe("champ_over", 100, 200, 1, 12'hF00, 12'hF00);
        probe("champ_sz", 101, 201, 1, 12'h123, 12'hF00);
    endtask

    task automatic test_err_goal();
        wr(2'd0, 45, 32'd7);
        checks++;
        if (wr_err !== 1'b1) begin
            errors++;
            $display("FAIL wr_err_id45 got %b want 1", wr_err);
        end
        wr(2'd3, 0, 32'd0);
        end_frame(1);
        probe("goal0_tl", 0, 0, 1, 12'h0D0, 12'h0D0);
        probe("goal0_br", 19, 19, 1, 12'h0D0, 12'h0D0);
        probe("goal0_out", 20, 19, 1, 12'h123, 12'h123);
        probe("goal_old", 310, 50, 1, 12'h123, 12'h123);
    endtask

    task automatic test_size_edge();
        wr(2'd0, 7, 32'd638);
        wr(2'd1, 7, 32'd100);
        end_frame(1);
        probe("edge_638", 638, 100, 1, 12'h000, 12'h000);
        probe("edge_639", 639, 100, 1, 12'h123, 12'h000);
        probe("edge_wrap", 0, 101, 1, 12'h123, 12'h123);
        probe("edge_637", 637, 100, 1, 12'h123, 12'h123);
        probe("blank", 638, 100, 0, 12'h000, 12'h000);
    endtask

    task automatic test_race_reset();
        test_reset();
        pix(10, 10, 1, 1, 12'h321, 1, 1, 2'd0, 0, 32'd5);
        end_frame(1);
        probe("race_drop", 5, 240, 1, 12'h123, 12'h123);
        probe("race_keep", 320, 240, 1, 12'h000, 12'h000);
        wr(2'd0, 3, 32'd50);
        pix(0, 500, 0, 0, 12'h000, 1);
        test_reset();
        end_frame(0);
        end_frame(1);
        probe("rst_arrays", 50, 240, 1, 12'h123, 12'h123);
        probe("rst_dot", 320, 240, 1, 12'h000, 12'h000);
    endtask

    task automatic test_random();
        for (int k = 0; k < 700; k++) begin
            int r, i, px, py;
            logic [1:0] f;
            logic [31:0] d;
            r = int'($urandom_range(0, 99));
            if (r < 20) begin
                f = 2'($urandom_range(0, 3));
                d = {$urandom} << 20;
                case (f)
                    2'd0: d = d | $urandom_range(0, 639);
                    2'd1: d = d | $urandom_range(0, 479);
                    2'd2: d = d | $urandom_range(0, 3);
                    default: d = ({$urandom} << 19)
                                | ($urandom_range(0, 470) << 10)
                                | $urandom_range(0, 630);
                endcase
                wr(f, int'($urandom_range(0, 46)), d);
            end else if (r < 26) begin
                end_frame($urandom_range(0, 1) == 1);
            end else if (r < 30) begin
                pix(int'($urandom_range(0, 639)), int'($urandom_range(0, 479)),
                    1, 1, 12'($urandom), $urandom_range(0, 1) == 1,
                    1, 2'($urandom_range(0, 2)), int'($urandom_range(0, 44)),
                    32'($urandom_range(0, 479)));
            end else begin
                i = int'($urandom_range(0, N - 1));
                if (r < 40) begin
                    px = agx + int'($urandom_range(0, 23)) - 2;
                    py = agy + int'($urandom_range(0, 23)) - 2;
                end else begin
                    px = ax[i] + int'($urandom_range(0, 6)) - 2;
                    py = ay[i] + int'($urandom_range(0, 6)) - 2;
                end
                if (px < 0) px = 0;
                if (py < 0) py = 0;
                pix(px, py, $urandom_range(0, 9) != 0, 0, 12'($urandom),
                    $urandom_range(0, 19) == 0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_defaults();
        test_commit();
        test_champion();
        test_err_goal();
        test_size_edge();
        test_race_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
